npu_inst_fetch: RTL

- Instruction fetch and prefetch queue that sits directly upstream of the NPU controller.
- Reads a program of INST_COUNT consecutive instruction words from the instruction SRAM, starting at BASE_ADDR.
- Buffers the words in a DEPTH-entry FIFO and presents them to the controller over a valid/ready handshake.
- Decouples the SRAM's fixed 1-cycle read latency from controller stalls.

---
 rtl/npu_inst_fetch.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/npu_inst_fetch.sv
// npu_inst_fetch: instruction fetch and prefetch queue in front of the NPU controller.
// Streams inst_count words from the instruction SRAM, starting at base_addr. The words pass
// through a DEPTH-entry FIFO and leave over a valid/ready handshake.
// Optional feature: define NPU_FETCH_PERF_EN to add the 32-bit stall_cycles counter output.
// The surrounding top level casts inst_data to instruction_t.

module npu_inst_fetch #(
  parameter int unsigned INST_W = 64,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         inst_count,
  output logic                     imem_rd_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_rd_data,
  output logic [INST_W-1:0]        inst_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         delivered,
  output logic [$clog2(DEPTH):0]   level
`ifdef NPU_FETCH_PERF_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned OccW = LvlW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    delivered_q, delivered_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Read data lands this cycle (the read strobe was high last cycle).
  logic                pend_q, pend_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [INST_W-1:0]   mem_q [DEPTH];

  logic                fifo_nonempty;
  logic                start_ok;
  logic                push;
  logic                pop;
  logic [OccW-1:0]     occ;
  logic                room;

  assign fifo_nonempty = (level_q != '0);
  assign start_ok      = (state_q == StIdle) && start && !flush;
  assign push          = pend_q && !flush;
  assign pop           = fifo_nonempty && inst_ready && !flush && (state_q == StFetch);

  // Space must be reserved for the word landing now and the word already requested.
  assign occ  = OccW'(level_q) + OccW'(pend_q) + OccW'(rd_en_q);
  assign room = occ < (DepthOcc + OccW'(pop));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush always wins and returns to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = (inst_count == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (flush) begin
          state_d = StIdle;
        end else if ((issued_q == count_q) && !rd_en_q && !pend_q && !fifo_nonempty) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Program registers and read issue; the strobe is registered, so the first read is
  // launched from the accepted start itself to keep start->inst_valid at 3 cycles.
  always_comb begin
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    pend_d      = rd_en_q && !flush;
    if (start_ok) begin
      base_d      = base_addr;
      count_d     = inst_count;
      issued_d    = '0;
      delivered_d = '0;
      if (inst_count != '0) begin
        rd_en_d  = 1'b1;
        addr_d   = base_addr;
        issued_d = CNT_W'(1);
      end
    end else if ((state_q == StFetch) && !flush) begin
      if (pop) begin
        delivered_d = delivered_q + CNT_W'(1);
      end
      if ((issued_q < count_q) && room) begin
        rd_en_d  = 1'b1;
        addr_d   = base_q + ADDR_W'(issued_q);
        issued_d = issued_q + CNT_W'(1);
      end
    end
  end

  // Program and read-issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
    end else begin
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
    end
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; contents are only visible through a non-empty head, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= imem_rd_data;
    end
  end

  // Datapath outputs; the head is masked while empty so outputs are zero out of reset.
  always_comb begin
    imem_rd_en = rd_en_q;
    imem_addr  = addr_q;
    inst_valid = fifo_nonempty;
    inst_data  = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    delivered  = delivered_q;
    level      = level_q;
  end

`ifdef NPU_FETCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter: fetch cycles without a pop; saturating, held outside fetch.
  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if ((state_q == StFetch) && !(fifo_nonempty && inst_ready) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
